// File: rtl/psum_drain_pkg.sv
// rtl/psum_drain_pkg.sv - shared constants and FSM encoding for the partial-sum drain
// Purpose: geometry of the 16x16x24-bit partial-sum latch array and the drain FSM states.
// Ports: none (package psum_pkg).
// Optional feature macro used by the bundle: PSUM_DRAIN_RELU_EN.
package psum_pkg;

    localparam int ROWS      = 16;
    localparam int COLS      = 16;
    localparam int PSUM_W    = 24;
    localparam int ROW_IDX_W = 4;
    localparam int ROW_W     = COLS * PSUM_W;
    localparam int ARRAY_W   = ROWS * ROW_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/psum_drain_if.sv
// rtl/psum_drain_if.sv - row-beat output stream between the drain and the writeback buffer
// Purpose: groups the valid/ready beat signals of the drained tile.
// Signals: out_valid, out_ready, out_data (one row), out_row (row index), out_last (final row).
// Modports: master (drain side), slave (writeback side).
interface psum_drain_if;
    import psum_pkg::*;

    logic                 out_valid;
    logic                 out_ready;
    logic [ROW_W-1:0]     out_data;
    logic [ROW_IDX_W-1:0] out_row;
    logic                 out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_row,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_row,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/psum_drain_row_select.sv
// rtl/psum_drain_row_select.sv - combinational ROWS:1 row mux from snapshot to output beat
// Purpose: picks snapshot row row_i; drives zero when en_i is low.
// Ports: snap_i (whole snapshot), row_i (row index), en_i (beat valid), data_o (selected row).
// Macro PSUM_DRAIN_RELU_EN: when defined, negative 24-bit lanes are forced to zero on the way out.
module psum_row_select
    import psum_pkg::*;
(
    input  logic [ARRAY_W-1:0]   snap_i,
    input  logic [ROW_IDX_W-1:0] row_i,
    input  logic                 en_i,
    output logic [ROW_W-1:0]     data_o
);

    logic [ROW_W-1:0] row_data;

    always_comb begin
        row_data = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (en_i && (row_i == ROW_IDX_W'(r))) begin
                row_data = snap_i[r*ROW_W +: ROW_W];
            end
        end
    end

`ifdef PSUM_DRAIN_RELU_EN
    // Masking is applied here rather than at capture so the snapshot keeps raw sums.
    logic [PSUM_W-1:0] lane;

    always_comb begin
        data_o = '0;
        lane   = '0;
        for (int c = 0; c < COLS; c++) begin
            lane = row_data[c*PSUM_W +: PSUM_W];
            data_o[c*PSUM_W +: PSUM_W] = lane[PSUM_W-1] ? '0 : lane;
        end
    end
`else
    assign data_o = row_data;
`endif

endmodule

// File: rtl/psum_drain.sv
// rtl/psum_drain.sv - snapshot the partial-sum latch array and drain it one row per beat
// Purpose: on start, captures latch_array_in so the MAC array can start the next tile,
//          then streams rows 0..ROWS-1 over a valid/ready interface and pulses done.
// Ports: clk, rst (sync, active-high), start (capture request), latch_array_in (flattened array),
//        busy (drain or done in progress), done (one-cycle pulse), out_if (psum_drain_if.master).
// Macro PSUM_DRAIN_RELU_EN: enables lane clamping inside psum_row_select.
module psum_drain
    import psum_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ARRAY_W-1:0] latch_array_in,
    output logic               busy,
    output logic               done,
    psum_drain_if.master       out_if
);

    state_e               state_q, state_d;
    logic [ROW_IDX_W-1:0] row_q, row_d;
    logic [ARRAY_W-1:0]   snap_q, snap_d;

    logic drain_active;
    logic row_is_last;

    assign drain_active = (state_q == DRAIN);
    assign row_is_last  = (row_q == ROW_IDX_W'(ROWS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            snap_q  <= snap_d;
        end
    end

    // out_valid is a pure function of state, so out_ready alone qualifies a transfer
    // in DRAIN and never feeds back into out_valid combinationally.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        snap_d  = snap_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRAIN;
                    row_d   = '0;
                    snap_d  = latch_array_in;
                end
            end
            DRAIN: begin
                if (out_if.out_ready) begin
                    if (row_is_last) begin
                        state_d = DONE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        out_if.out_valid = drain_active;
        out_if.out_row   = drain_active ? row_q : '0;
        out_if.out_last  = drain_active && row_is_last;
        busy             = (state_q != IDLE);
        done             = (state_q == DONE);
    end

    psum_row_select u_row_select (
        .snap_i (snap_q),
        .row_i  (row_q),
        .en_i   (drain_active),
        .data_o (out_if.out_data)
    );

endmodule

// File: tb/tb_psum_drain.sv
// tb/tb_psum_drain.sv - self-checking bench for psum_drain
module tb_psum_drain;
    import psum_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [ARRAY_W-1:0] latch_array_in;
    logic               busy;
    logic               done;

    psum_drain_if dif ();

    psum_drain dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .latch_array_in (latch_array_in),
        .busy           (busy),
        .done           (done),
        .out_if         (dif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [PSUM_W-1:0] fill_m [ROWS][COLS];
    logic [PSUM_W-1:0] cap_m  [ROWS][COLS];

    logic [ROW_IDX_W-1:0] q_row  [$];
    logic [ROW_W-1:0]     q_data [$];
    logic                 q_last [$];
    int stab_err;
    int done_cnt;
    int timed_out;

    function automatic logic [ROW_W-1:0] exp_row(input int r);
        logic [ROW_W-1:0]  e;
        logic [PSUM_W-1:0] v;
        e = '0;
        for (int c = 0; c < COLS; c++) begin
            v = cap_m[r][c];
`ifdef PSUM_DRAIN_RELU_EN
            if (v[PSUM_W-1]) v = '0;
`endif
            e[c*PSUM_W +: PSUM_W] = v;
        end
        return e;
    endfunction

    task automatic drive_array();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                latch_array_in[(r*COLS + c)*PSUM_W +: PSUM_W] = fill_m[r][c];
    endtask

    task automatic fill(input int kind);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                case (kind)
                    0:       fill_m[r][c] = PSUM_W'(r*16 + c);
                    1:       fill_m[r][c] = PSUM_W'($urandom);
                    2:       fill_m[r][c] = (c % 2 == 0) ? 24'h800001 : 24'h000005;
                    default: fill_m[r][c] = 24'hFFFFFF;
                endcase
        drive_array();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        cap_m = fill_m;
        #1;
        start = 1'b0;
    endtask

    // Drains one tile, recording accepted beats; mode 0 ready=1, 1 ready=1,0,0,..., 2 random.
    task automatic collect(input int mode, input int restart_at);
        logic                 prev_hold;
        logic [ROW_IDX_W-1:0] p_row;
        logic [ROW_W-1:0]     p_data;
        logic                 p_last;
        logic                 rdy;
        int                   tail;
        q_row.delete(); q_data.delete(); q_last.delete();
        stab_err = 0; done_cnt = 0; timed_out = 1;
        prev_hold = 1'b0; p_row = '0; p_data = '0; p_last = 1'b0; tail = -1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            start = 1'b0;
            if (done) begin
                done_cnt++;
                if (tail < 0) tail = 20;
            end
            if (tail == 0) begin
                timed_out = 0;
                break;
            end
            if (tail > 0) tail--;
            if (dif.out_valid) begin
                if (prev_hold && (dif.out_row !== p_row || dif.out_data !== p_data ||
                                  dif.out_last !== p_last))
                    stab_err++;
            end else if (prev_hold) begin
                stab_err++;
            end
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            dif.out_ready = rdy;
            if (dif.out_valid && rdy) begin
                q_row.push_back(dif.out_row);
                q_data.push_back(dif.out_data);
                q_last.push_back(dif.out_last);
                if (restart_at >= 0 && q_row.size() == restart_at + 1) start = 1'b1;
            end
            prev_hold = dif.out_valid && !rdy;
            p_row = dif.out_row; p_data = dif.out_data; p_last = dif.out_last;
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        dif.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%0b exp=0", done); end
        checks++; if (dif.out_valid !== 1'b0 || dif.out_last !== 1'b0 || dif.out_row !== '0 || dif.out_data !== '0) begin
            errors++; $display("FAIL reset_outputs valid=%0b last=%0b row=%0d data=%h exp all zero",
                               dif.out_valid, dif.out_last, dif.out_row, dif.out_data);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream();
        fill(0);
        dif.out_ready = 1'b1;
        start = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stream_busy_T got=%0b exp=0", busy); end
        @(posedge clk);
        cap_m = fill_m;
        #1;
        start = 1'b0;
        for (int k = 0; k < ROWS; k++) begin
            checks++;
            if (dif.out_valid !== 1'b1 || dif.out_row !== ROW_IDX_W'(k) || dif.out_data !== exp_row(k) ||
                dif.out_last !== (k == ROWS - 1) || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL stream_beat%0d valid=%0b row=%0d last=%0b busy=%0b done=%0b data=%h exp data=%h",
                         k, dif.out_valid, dif.out_row, dif.out_last, busy, done, dif.out_data, exp_row(k));
            end
            @(posedge clk);
            #1;
        end
        checks++; if (done !== 1'b1 || busy !== 1'b1 || dif.out_valid !== 1'b0) begin
            errors++; $display("FAIL stream_done_T17 done=%0b busy=%0b valid=%0b exp 1 1 0", done, busy, dif.out_valid);
        end
        @(posedge clk);
        #1;
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL stream_idle_T18 done=%0b busy=%0b exp 0 0", done, busy);
        end
        dif.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        for (int pass = 0; pass < 2; pass++) begin
            fill(pass);
            pulse_start();
            collect(pass + 1, -1);
            checks++; if (timed_out !== 0 || q_row.size() !== ROWS) begin
                errors++; $display("FAIL bp%0d_beats got=%0d timeout=%0d exp=%0d", pass, q_row.size(), timed_out, ROWS);
            end
            for (int k = 0; k < q_row.size() && k < ROWS; k++) begin
                checks++;
                if (q_row[k] !== ROW_IDX_W'(k) || q_data[k] !== exp_row(k) || q_last[k] !== (k == ROWS - 1)) begin
                    errors++; $display("FAIL bp%0d_beat%0d row=%0d last=%0b data=%h exp data=%h",
                                       pass, k, q_row[k], q_last[k], q_data[k], exp_row(k));
                end
            end
            checks++; if (stab_err !== 0) begin errors++; $display("FAIL bp%0d_stable got=%0d exp=0", pass, stab_err); end
            checks++; if (done_cnt !== 1) begin errors++; $display("FAIL bp%0d_done got=%0d exp=1", pass, done_cnt); end
        end
    endtask

    task automatic test_isolation();
        fill(1);
        pulse_start();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                fill_m[r][c] = 24'hFFFFFF;
        drive_array();
        collect(0, -1);
        checks++; if (q_row.size() !== ROWS) begin errors++; $display("FAIL iso_beats got=%0d exp=%0d", q_row.size(), ROWS); end
        for (int k = 0; k < q_row.size() && k < ROWS; k++) begin
            checks++;
            if (q_data[k] !== exp_row(k)) begin
                errors++; $display("FAIL iso_beat%0d data=%h exp=%h", k, q_data[k], exp_row(k));
            end
        end
    endtask

    task automatic test_start_ignored();
        fill(0);
        pulse_start();
        fill(1);
        collect(0, 5);
        checks++; if (q_row.size() !== ROWS) begin errors++; $display("FAIL ign_beats got=%0d exp=%0d", q_row.size(), ROWS); end
        for (int k = 0; k < q_row.size() && k < ROWS; k++) begin
            checks++;
            if (q_row[k] !== ROW_IDX_W'(k) || q_data[k] !== exp_row(k)) begin
                errors++; $display("FAIL ign_beat%0d row=%0d data=%h exp data=%h", k, q_row[k], q_data[k], exp_row(k));
            end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL ign_done got=%0d exp=1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        fill(1);
        pulse_start();
        dif.out_ready = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        dif.out_ready = 1'b0;
        checks++; if (dif.out_row !== ROW_IDX_W'(7)) begin errors++; $display("FAIL rmid_row got=%0d exp=7", dif.out_row); end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || dif.out_valid !== 1'b0 || dif.out_last !== 1'b0 ||
                      dif.out_row !== '0 || dif.out_data !== '0) begin
            errors++; $display("FAIL rmid_outputs busy=%0b done=%0b valid=%0b last=%0b row=%0d data=%h exp all zero",
                               busy, done, dif.out_valid, dif.out_last, dif.out_row, dif.out_data);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checks++; if (done !== 1'b0 || dif.out_valid !== 1'b0) begin
                errors++; $display("FAIL rmid_quiet%0d done=%0b valid=%0b exp 0 0", i, done, dif.out_valid);
            end
        end
        fill(1);
        pulse_start();
        collect(2, -1);
        checks++; if (q_row.size() !== ROWS) begin errors++; $display("FAIL rmid_beats got=%0d exp=%0d", q_row.size(), ROWS); end
        for (int k = 0; k < q_row.size() && k < ROWS; k++) begin
            checks++;
            if (q_row[k] !== ROW_IDX_W'(k) || q_data[k] !== exp_row(k)) begin
                errors++; $display("FAIL rmid_beat%0d row=%0d data=%h exp data=%h", k, q_row[k], q_data[k], exp_row(k));
            end
        end
    endtask

    task automatic test_relu();
        logic [PSUM_W-1:0] neg_exp;
`ifdef PSUM_DRAIN_RELU_EN
        neg_exp = 24'h000000;
`else
        neg_exp = 24'h800001;
`endif
        fill(2);
        pulse_start();
        collect(2, -1);
        checks++; if (q_row.size() !== ROWS) begin errors++; $display("FAIL relu_beats got=%0d exp=%0d", q_row.size(), ROWS); end
        for (int k = 0; k < q_row.size() && k < ROWS; k++) begin
            checks++;
            if (q_data[k][PSUM_W-1:0] !== neg_exp || q_data[k][2*PSUM_W-1:PSUM_W] !== 24'h000005 ||
                q_data[k] !== exp_row(k)) begin
                errors++; $display("FAIL relu_beat%0d data=%h exp=%h", k, q_data[k], exp_row(k));
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        latch_array_in = '0;
        dif.out_ready = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_isolation();
        test_start_ignored();
        test_reset_mid();
        test_relu();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
